// File: rtl/multu_hilo.sv
// multu_hilo: sequential 32x32 unsigned shift-add multiplier with HI/LO pair.
// One partial-product step per clock. A HILO_WR that arrives while the
// multiply is still running is held as "pending" and committed on the final
// step, so the ALU control stage never has to stall.
module multu_hilo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  Signal,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        ready
);

  localparam logic [5:0] OP_MUL     = 6'b011001;
  localparam logic [5:0] OP_HILO_WR = 6'b111111;
  localparam logic [5:0] OP_MFHI    = 6'b010000;
  localparam logic [5:0] OP_MFLO    = 6'b010010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg;
  logic [31:0] mcand_reg;
  logic [63:0] p_reg;
  logic        pending_reg;
  logic [31:0] hi_reg, lo_reg;

  // Datapath control strobes produced by the next-state logic
  logic        do_load;
  logic        do_step;
  logic        do_set_pending;
  logic        commit_step;   // commit the product produced by this edge's step
  logic        commit_hold;   // commit the already-finished product held in P

  logic [32:0] sum;
  logic [63:0] p_step;
  logic        last_step;

  // The 33-bit sum keeps the carry, so the shifted product never overflows
  assign sum       = {1'b0, p_reg[63:32]} + {1'b0, (p_reg[0] ? mcand_reg : 32'd0)};
  assign p_step    = {sum, p_reg[31:1]};
  assign last_step = (cnt_reg == 6'd31);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and datapath strobes; command decode depends on state
  always_comb begin
    state_next     = state_reg;
    do_load        = 1'b0;
    do_step        = 1'b0;
    do_set_pending = 1'b0;
    commit_step    = 1'b0;
    commit_hold    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (Signal == OP_MUL) begin
          do_load    = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (pending_reg) begin
          // Commit already requested: finish regardless of the command
          do_step = 1'b1;
          if (last_step) begin
            commit_step = 1'b1;
            state_next  = S_IDLE;
          end
        end else if (Signal == OP_MUL || Signal == OP_HILO_WR) begin
          do_step        = 1'b1;
          do_set_pending = (Signal == OP_HILO_WR);
          if (last_step) begin
            if (Signal == OP_HILO_WR) begin
              commit_step = 1'b1;
              state_next  = S_IDLE;
            end else begin
              state_next  = S_DONE;
            end
          end
        end else begin
          // Any other command abandons the multiply; HI/LO untouched
          state_next = S_IDLE;
        end
      end
      S_DONE: begin
        if (Signal == OP_HILO_WR) begin
          commit_hold = 1'b1;
          state_next  = S_IDLE;
        end else if (Signal == OP_MUL) begin
          do_load    = 1'b1;
          state_next = S_RUN;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Multiplier datapath and the committed HI/LO pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= 6'd0;
      mcand_reg   <= 32'd0;
      p_reg       <= 64'd0;
      pending_reg <= 1'b0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
    end else begin
      if (do_load) begin
        mcand_reg   <= dataA;
        p_reg       <= {32'd0, dataB};
        cnt_reg     <= 6'd0;
        pending_reg <= 1'b0;
      end else if (do_step) begin
        p_reg   <= p_step;
        cnt_reg <= cnt_reg + 6'd1;
        if (do_set_pending) pending_reg <= 1'b1;
      end
      if (commit_step) begin
        hi_reg      <= p_step[63:32];
        lo_reg      <= p_step[31:0];
        pending_reg <= 1'b0;
      end else if (commit_hold) begin
        hi_reg <= p_reg[63:32];
        lo_reg <= p_reg[31:0];
      end
    end
  end

  // Read-back always shows committed HI/LO, never the partial product
  always_comb begin
    dataOut = 32'd0;
    if (Signal == OP_MFHI)      dataOut = hi_reg;
    else if (Signal == OP_MFLO) dataOut = lo_reg;
  end

  assign busy  = (state_reg == S_RUN);
  assign ready = (state_reg == S_DONE);

endmodule
